// File: rtl/mem_arbiter.sv
// Memory-side arbiter for the L1 caches: buffers icache/dcache requests in per-source FIFOs,
// round-robins between them and runs one memory request/response transaction at a time.
module mem_arbiter #(
    parameter int QDEPTH   = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 128,
    parameter int OFFSET_W = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ic_req_ren,
    input  logic [ADDR_W-1:0] ic_req_addr,

    input  logic              dc_req_ren,
    input  logic              dc_req_wen,
    input  logic [ADDR_W-1:0] dc_req_addr,
    input  logic [DATA_W-1:0] dc_req_data,

    output logic              ic_rec_en,
    output logic [ADDR_W-1:0] ic_rec_addr,
    output logic [DATA_W-1:0] ic_rec_cacheline,
    output logic              dc_rec_en,
    output logic [ADDR_W-1:0] dc_rec_addr,
    output logic [DATA_W-1:0] dc_rec_cacheline,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_write,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_data,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,

    output logic              overflow
);

    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = $clog2(QDEPTH + 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFFSET_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    typedef enum logic {
        SRC_IC = 1'b0,
        SRC_DC = 1'b1
    } src_e;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // FIFO storage is not reset: only the pointers/counters define what is valid.
    logic [ADDR_W-1:0] ic_addr_mem [QDEPTH];
    logic [ADDR_W-1:0] dc_addr_mem [QDEPTH];
    logic [DATA_W-1:0] dc_data_mem [QDEPTH];
    logic              dc_wr_mem   [QDEPTH];

    logic [PTR_W-1:0] ic_wr_ptr_q, ic_wr_ptr_d, ic_rd_ptr_q, ic_rd_ptr_d;
    logic [PTR_W-1:0] dc_wr_ptr_q, dc_wr_ptr_d, dc_rd_ptr_q, dc_rd_ptr_d;
    logic [CNT_W-1:0] ic_cnt_q, ic_cnt_d, dc_cnt_q, dc_cnt_d;

    state_e state_q, state_d;
    src_e   last_grant_q, last_grant_d;

    logic              mem_req_valid_q, mem_req_valid_d;
    logic              mem_req_write_q, mem_req_write_d;
    logic [ADDR_W-1:0] mem_req_addr_q, mem_req_addr_d;
    logic [DATA_W-1:0] mem_req_data_q, mem_req_data_d;

    logic              ic_rec_en_q, ic_rec_en_d;
    logic [ADDR_W-1:0] ic_rec_addr_q, ic_rec_addr_d;
    logic [DATA_W-1:0] ic_rec_line_q, ic_rec_line_d;
    logic              dc_rec_en_q, dc_rec_en_d;
    logic [ADDR_W-1:0] dc_rec_addr_q, dc_rec_addr_d;
    logic [DATA_W-1:0] dc_rec_line_q, dc_rec_line_d;

    logic overflow_q, overflow_d;

    logic ic_pop, dc_pop;
    logic ic_push, dc_push;
    logic ic_push_ok, dc_push_ok;
    logic ic_full, dc_full;
    logic ic_nonempty, dc_nonempty;
    logic pick_dc;

    assign ic_push     = ic_req_ren;
    assign dc_push     = dc_req_ren | dc_req_wen;
    assign ic_full     = (ic_cnt_q == CNT_W'(QDEPTH));
    assign dc_full     = (dc_cnt_q == CNT_W'(QDEPTH));
    assign ic_nonempty = (ic_cnt_q != '0);
    assign dc_nonempty = (dc_cnt_q != '0);

    // A pop in the same cycle frees the slot, so a push onto a full FIFO is still taken.
    assign ic_push_ok  = ic_push & (~ic_full | ic_pop);
    assign dc_push_ok  = dc_push & (~dc_full | dc_pop);

    // On a tie the source that did not win last time gets the grant.
    assign pick_dc = dc_nonempty & (~ic_nonempty | (last_grant_q == SRC_IC));

    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_req_write_d = mem_req_write_q;
        mem_req_addr_d  = mem_req_addr_q;
        mem_req_data_d  = mem_req_data_q;
        ic_rec_en_d     = 1'b0;
        ic_rec_addr_d   = ic_rec_addr_q;
        ic_rec_line_d   = ic_rec_line_q;
        dc_rec_en_d     = 1'b0;
        dc_rec_addr_d   = dc_rec_addr_q;
        dc_rec_line_d   = dc_rec_line_q;
        ic_pop          = 1'b0;
        dc_pop          = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (ic_nonempty || dc_nonempty) begin
                    state_d         = ST_REQ;
                    last_grant_d    = pick_dc ? SRC_DC : SRC_IC;
                    mem_req_valid_d = 1'b1;
                    if (pick_dc) begin
                        mem_req_write_d = dc_wr_mem[dc_rd_ptr_q];
                        mem_req_addr_d  = dc_addr_mem[dc_rd_ptr_q];
                        mem_req_data_d  = dc_data_mem[dc_rd_ptr_q];
                    end else begin
                        mem_req_write_d = 1'b0;
                        mem_req_addr_d  = ic_addr_mem[ic_rd_ptr_q];
                        mem_req_data_d  = '0;
                    end
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_d         = ST_WAIT;
                    mem_req_valid_d = 1'b0;
                end
            end
            ST_WAIT: begin
                // The head entry stays queued until memory answers, then it is retired.
                if (mem_rsp_valid) begin
                    state_d = ST_IDLE;
                    if (last_grant_q == SRC_DC) begin
                        dc_pop = 1'b1;
                        if (!mem_req_write_q) begin
                            dc_rec_en_d   = 1'b1;
                            dc_rec_addr_d = mem_req_addr_q;
                            dc_rec_line_d = mem_rsp_data;
                        end
                    end else begin
                        ic_pop = 1'b1;
                        if (!mem_req_write_q) begin
                            ic_rec_en_d   = 1'b1;
                            ic_rec_addr_d = mem_req_addr_q;
                            ic_rec_line_d = mem_rsp_data;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        ic_wr_ptr_d = ic_push_ok ? ptr_inc(ic_wr_ptr_q) : ic_wr_ptr_q;
        ic_rd_ptr_d = ic_pop ? ptr_inc(ic_rd_ptr_q) : ic_rd_ptr_q;
        ic_cnt_d    = ic_cnt_q + CNT_W'(ic_push_ok) - CNT_W'(ic_pop);
        dc_wr_ptr_d = dc_push_ok ? ptr_inc(dc_wr_ptr_q) : dc_wr_ptr_q;
        dc_rd_ptr_d = dc_pop ? ptr_inc(dc_rd_ptr_q) : dc_rd_ptr_q;
        dc_cnt_d    = dc_cnt_q + CNT_W'(dc_push_ok) - CNT_W'(dc_pop);
        overflow_d  = overflow_q
                    | (ic_push & ic_full & ~ic_pop)
                    | (dc_push & dc_full & ~dc_pop);
    end

    always_ff @(posedge clk) begin
        if (ic_push_ok) begin
            ic_addr_mem[ic_wr_ptr_q] <= ic_req_addr & LINE_MASK;
        end
        if (dc_push_ok) begin
            dc_wr_mem[dc_wr_ptr_q]   <= dc_req_wen;
            dc_addr_mem[dc_wr_ptr_q] <= dc_req_addr & LINE_MASK;
            dc_data_mem[dc_wr_ptr_q] <= dc_req_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            last_grant_q    <= SRC_DC;
            ic_wr_ptr_q     <= '0;
            ic_rd_ptr_q     <= '0;
            ic_cnt_q        <= '0;
            dc_wr_ptr_q     <= '0;
            dc_rd_ptr_q     <= '0;
            dc_cnt_q        <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_write_q <= 1'b0;
            mem_req_addr_q  <= '0;
            mem_req_data_q  <= '0;
            ic_rec_en_q     <= 1'b0;
            ic_rec_addr_q   <= '0;
            ic_rec_line_q   <= '0;
            dc_rec_en_q     <= 1'b0;
            dc_rec_addr_q   <= '0;
            dc_rec_line_q   <= '0;
            overflow_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            last_grant_q    <= last_grant_d;
            ic_wr_ptr_q     <= ic_wr_ptr_d;
            ic_rd_ptr_q     <= ic_rd_ptr_d;
            ic_cnt_q        <= ic_cnt_d;
            dc_wr_ptr_q     <= dc_wr_ptr_d;
            dc_rd_ptr_q     <= dc_rd_ptr_d;
            dc_cnt_q        <= dc_cnt_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_write_q <= mem_req_write_d;
            mem_req_addr_q  <= mem_req_addr_d;
            mem_req_data_q  <= mem_req_data_d;
            ic_rec_en_q     <= ic_rec_en_d;
            ic_rec_addr_q   <= ic_rec_addr_d;
            ic_rec_line_q   <= ic_rec_line_d;
            dc_rec_en_q     <= dc_rec_en_d;
            dc_rec_addr_q   <= dc_rec_addr_d;
            dc_rec_line_q   <= dc_rec_line_d;
            overflow_q      <= overflow_d;
        end
    end

    assign mem_req_valid    = mem_req_valid_q;
    assign mem_req_write    = mem_req_write_q;
    assign mem_req_addr     = mem_req_addr_q;
    assign mem_req_data     = mem_req_data_q;
    assign ic_rec_en        = ic_rec_en_q;
    assign ic_rec_addr      = ic_rec_addr_q;
    assign ic_rec_cacheline = ic_rec_line_q;
    assign dc_rec_en        = dc_rec_en_q;
    assign dc_rec_addr      = dc_rec_addr_q;
    assign dc_rec_cacheline = dc_rec_line_q;
    assign overflow         = overflow_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level model built from per-source queues.
module tb_mem_arbiter;

    localparam int QDEPTH = 4;
    localparam int AW     = 32;
    localparam int DW     = 128;
    localparam logic [AW-1:0] MASK = 32'hFFFF_FFF0;

    logic          clk = 1'b0;
    logic          rst;
    logic          ic_req_ren;
    logic [AW-1:0] ic_req_addr;
    logic          dc_req_ren, dc_req_wen;
    logic [AW-1:0] dc_req_addr;
    logic [DW-1:0] dc_req_data;
    logic          ic_rec_en, dc_rec_en;
    logic [AW-1:0] ic_rec_addr, dc_rec_addr;
    logic [DW-1:0] ic_rec_cacheline, dc_rec_cacheline;
    logic          mem_req_valid, mem_req_ready, mem_req_write;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_data;
    logic          mem_rsp_valid;
    logic [DW-1:0] mem_rsp_data;
    logic          overflow;

    mem_arbiter #(.QDEPTH(QDEPTH), .ADDR_W(AW), .DATA_W(DW), .OFFSET_W(4)) dut (
        .clk(clk), .rst(rst),
        .ic_req_ren(ic_req_ren), .ic_req_addr(ic_req_addr),
        .dc_req_ren(dc_req_ren), .dc_req_wen(dc_req_wen),
        .dc_req_addr(dc_req_addr), .dc_req_data(dc_req_data),
        .ic_rec_en(ic_rec_en), .ic_rec_addr(ic_rec_addr), .ic_rec_cacheline(ic_rec_cacheline),
        .dc_rec_en(dc_rec_en), .dc_rec_addr(dc_rec_addr), .dc_rec_cacheline(dc_rec_cacheline),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_miscmp = 0;
    int ic_pulses = 0;
    int dc_pulses = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    req_t icq[$];
    req_t dcq[$];
    req_t cur;
    bit   cur_dc;
    bit   last_dc;
    int   phase;      // 0: nothing in flight, 1: request offered, 2: awaiting response
    logic          exp_valid, exp_ic_rec, exp_dc_rec, exp_ovf;
    logic [AW-1:0] exp_rec_addr;
    logic [DW-1:0] exp_rec_line;

    task automatic model_step();
        req_t r;
        if (rst) begin
            icq.delete();
            dcq.delete();
            phase = 0; last_dc = 1'b1;
            exp_valid = 0; exp_ic_rec = 0; exp_dc_rec = 0; exp_ovf = 0;
            exp_rec_addr = '0; exp_rec_line = '0;
            return;
        end
        exp_ic_rec = 0;
        exp_dc_rec = 0;
        if (phase == 0) begin
            if (icq.size() + dcq.size() > 0) begin
                cur_dc = (dcq.size() > 0) && (icq.size() == 0 || !last_dc);
                last_dc = cur_dc;
                cur = cur_dc ? dcq[0] : icq[0];
                exp_valid = 1;
                phase = 1;
            end
        end else if (phase == 1) begin
            if (mem_req_ready) begin
                exp_valid = 0;
                phase = 2;
            end
        end else begin
            if (mem_rsp_valid) begin
                if (cur_dc) void'(dcq.pop_front());
                else        void'(icq.pop_front());
                if (!cur.wr) begin
                    if (cur_dc) exp_dc_rec = 1; else exp_ic_rec = 1;
                    exp_rec_addr = cur.addr;
                    exp_rec_line = mem_rsp_data;
                end
                phase = 0;
            end
        end
        // Retirement is applied first, so a freed slot accepts this cycle's request.
        if (ic_req_ren) begin
            r.wr = 0; r.addr = ic_req_addr & MASK; r.data = '0;
            if (icq.size() < QDEPTH) icq.push_back(r); else exp_ovf = 1;
        end
        if (dc_req_ren || dc_req_wen) begin
            r.wr = dc_req_wen; r.addr = dc_req_addr & MASK; r.data = dc_req_data;
            if (dcq.size() < QDEPTH) dcq.push_back(r); else exp_ovf = 1;
        end
    endtask

    task automatic compare_all();
        chk("req_valid", mem_req_valid, exp_valid);
        chk("ic_rec_en", ic_rec_en, exp_ic_rec);
        chk("dc_rec_en", dc_rec_en, exp_dc_rec);
        chk("overflow", overflow, exp_ovf);
        if (exp_valid) begin
            chk("req_addr", mem_req_addr, cur.addr);
            chk("req_write", mem_req_write, cur.wr);
            if (cur.wr) chk("req_data", mem_req_data, cur.data);
        end
        if (exp_ic_rec) begin
            chk("ic_rec_addr", ic_rec_addr, exp_rec_addr);
            chk("ic_rec_line", ic_rec_cacheline, exp_rec_line);
        end
        if (exp_dc_rec) begin
            chk("dc_rec_addr", dc_rec_addr, exp_rec_addr);
            chk("dc_rec_line", dc_rec_cacheline, exp_rec_line);
        end
        if (ic_rec_en === 1'b1) ic_pulses++;
        if (dc_rec_en === 1'b1) dc_pulses++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        ic_req_ren = 0; dc_req_ren = 0; dc_req_wen = 0; mem_rsp_valid = 0;
    endtask

    task automatic reset_dut();
        rst = 1; tick(); rst = 0;
    endtask

    task automatic wait_valid(output logic [AW-1:0] a);
        for (int i = 0; i < 40 && mem_req_valid !== 1'b1; i++) tick();
        chk("req_valid_seen", mem_req_valid, 1'b1);
        a = mem_req_addr;
    endtask

    task automatic serve(input logic [DW-1:0] d, output logic [AW-1:0] a);
        mem_req_ready = 1;
        wait_valid(a);
        tick();
        mem_rsp_valid = 1; mem_rsp_data = d;
        tick();
    endtask

    task automatic push_ic(input logic [AW-1:0] a);
        ic_req_ren = 1; ic_req_addr = a;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] a, a0;
        int icp, dcp;
        rst = 1; ic_req_ren = 0; ic_req_addr = '0; dc_req_ren = 0; dc_req_wen = 0;
        dc_req_addr = '0; dc_req_data = '0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
        tick(); tick();
        chk("rst_valid", mem_req_valid, 1'b0);
        chk("rst_ic_rec", ic_rec_en, 1'b0);
        chk("rst_dc_rec", dc_rec_en, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_req_addr", mem_req_addr, '0);
        chk("rst_ic_rec_line", ic_rec_cacheline, '0);
        rst = 0;

        // single IC miss with misaligned address, response three cycles after handshake
        mem_req_ready = 1;
        push_ic(32'h1234); tick();
        wait_valid(a);
        chk("t1_aligned_addr", a, 32'h1230);
        tick();
        tick(); tick();
        mem_rsp_valid = 1; mem_rsp_data = 128'hD00D_F00D_0123_4567_89AB_CDEF_CAFE_BEEF;
        tick();
        chk("t1_fill_en", ic_rec_en, 1'b1);
        chk("t1_fill_line", ic_rec_cacheline, 128'hD00D_F00D_0123_4567_89AB_CDEF_CAFE_BEEF);
        chk("t1_fill_addr", ic_rec_addr, 32'h1230);
        tick(); tick();
        chk("t1_ic_pulses", ic_pulses, 1);
        chk("t1_dc_pulses", dc_pulses, 0);

        // simultaneous ties after reset: IC, DC, IC, DC
        reset_dut();
        push_ic(32'h100); dc_req_ren = 1; dc_req_addr = 32'h200; tick();
        push_ic(32'h110); dc_req_ren = 1; dc_req_addr = 32'h210; tick();
        serve(128'h1, a); chk("t2_order0", a, 32'h100);
        serve(128'h2, a); chk("t2_order1", a, 32'h200);
        serve(128'h3, a); chk("t2_order2", a, 32'h110);
        serve(128'h4, a); chk("t2_order3", a, 32'h210);

        // DC writeback produces no fill pulse
        icp = ic_pulses; dcp = dc_pulses;
        dc_req_wen = 1; dc_req_addr = 32'h85; dc_req_data = 128'hAAAA_5555_AAAA_5555_1111_2222_3333_4444;
        tick();
        wait_valid(a);
        chk("t3_addr", a, 32'h80);
        chk("t3_write", mem_req_write, 1'b1);
        chk("t3_data", mem_req_data, 128'hAAAA_5555_AAAA_5555_1111_2222_3333_4444);
        tick();
        mem_rsp_valid = 1; tick(); tick(); tick();
        chk("t3_no_ic_fill", ic_pulses, icp);
        chk("t3_no_dc_fill", dc_pulses, dcp);
        chk("t3_idle", mem_req_valid, 1'b0);

        // ready held low for six cycles
        mem_req_ready = 0;
        push_ic(32'h4448); tick();
        wait_valid(a0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t4_hold_valid", mem_req_valid, 1'b1);
            chk("t4_hold_addr", mem_req_addr, 32'h4440);
        end
        mem_req_ready = 1; tick();
        chk("t4_issued", mem_req_valid, 1'b0);
        mem_rsp_valid = 1; tick();

        // overflow: QDEPTH+1 requests while memory stalls
        reset_dut();
        mem_req_ready = 0;
        for (int i = 0; i <= QDEPTH; i++) begin
            push_ic(32'h1003 + 32'(i * 16)); tick();
        end
        chk("t5_ovf_set", overflow, 1'b1);
        for (int i = 0; i < QDEPTH; i++) begin
            serve(128'(i), a);
            chk("t5_order", a, 32'h1000 + 32'(i * 16));
        end
        tick(); tick();
        chk("t5_drop", mem_req_valid, 1'b0);
        chk("t5_ovf_sticky", overflow, 1'b1);

        // push and pop in the same cycle on a full FIFO
        reset_dut();
        mem_req_ready = 0;
        for (int i = 0; i < QDEPTH; i++) begin
            push_ic(32'h2000 + 32'(i * 16)); tick();
        end
        wait_valid(a);
        mem_req_ready = 1; tick();
        mem_req_ready = 0;
        mem_rsp_valid = 1; push_ic(32'h2F00); tick();
        chk("t5b_no_ovf", overflow, 1'b0);
        for (int i = 1; i <= QDEPTH; i++) serve(128'(i), a);
        chk("t5b_last", a, 32'h2F00);

        // reset while waiting for a response, late response ignored
        reset_dut();
        mem_req_ready = 1;
        push_ic(32'h2224); tick();
        wait_valid(a);
        tick();
        rst = 1; tick(); rst = 0;
        mem_rsp_valid = 1; mem_rsp_data = 128'hBAD; tick();
        chk("t6_no_fill", ic_rec_en, 1'b0);
        chk("t6_valid", mem_req_valid, 1'b0);
        chk("t6_rec_line", ic_rec_cacheline, '0);
        chk("t6_req_addr", mem_req_addr, '0);
        push_ic(32'h3338); tick();
        serve(128'h77, a);
        chk("t6_reissue", a, 32'h3330);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 399) == 0);
            mem_req_ready = $urandom_range(0, 1);
            mem_rsp_valid = ($urandom_range(0, 2) == 0);
            mem_rsp_data = {$urandom, $urandom, $urandom, $urandom};
            ic_req_ren = ($urandom_range(0, 5) == 0);
            ic_req_addr = $urandom;
            case ($urandom_range(0, 7))
                0: dc_req_ren = 1;
                1: dc_req_wen = 1;
                default: ;
            endcase
            dc_req_addr = $urandom;
            dc_req_data = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        rst = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
